rmt_pkt_filter: RTL and testbench

Ingress classifier that sits directly upstream of `rmt_wrapper`. It inspects the first 512-bit beat of every AXI-Stream packet and checks for a VLAN-tagged IPv4 frame carrying UDP. Matching packets are forwarded unchanged through a one-stage registered output into the RMT pipeline; all other packets are consumed and discarded. Pass and drop counts are exported for status readout.

---
 rtl/rmt_pkt_filter.sv | 64 ++++++
 tb/tb_rmt_pkt_filter.sv | 115 +++++++++++
 2 files changed

// File: rtl/rmt_pkt_filter.sv
// rmt_pkt_filter: classifies packets as VLAN/IPv4/UDP on their first beat, forwards
// matches through a one-stage output register and silently drops everything else.
module rmt_pkt_filter #(
  parameter int          C_S_AXIS_DATA_WIDTH  = 512,
  parameter int          C_S_AXIS_TUSER_WIDTH = 128,
  parameter logic [15:0] ETHERTYPE_MATCH      = 16'h0008,
  parameter logic [7:0]  PROTO_MATCH          = 8'h11,
  parameter int          CNT_WIDTH            = 32
) (
  input  logic                              clk,
  input  logic                              aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic [CNT_WIDTH-1:0]              pkt_pass_cnt,
  output logic [CNT_WIDTH-1:0]              pkt_drop_cnt
);
  localparam logic [1:0] IDLE = 2'd0, FWD = 2'd1, DROP = 2'd2;
  logic [1:0] state;
  logic match, drop_beat, accept, fwd_beat;
  assign match = s_axis_tdata[143:128] == ETHERTYPE_MATCH && s_axis_tdata[223:216] == PROTO_MATCH;
  assign drop_beat = state == DROP || (state == IDLE && !match);
  // drops never wait on the egress side
  assign s_axis_tready = drop_beat || !m_axis_tvalid || m_axis_tready;
  assign accept = s_axis_tvalid && s_axis_tready;
  assign fwd_beat = accept && !drop_beat;
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      pkt_pass_cnt  <= '0;
      pkt_drop_cnt  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
    end else begin
      if (accept)
        state <= s_axis_tlast ? IDLE : state == IDLE ? (match ? FWD : DROP) : state;
      if (accept && state == IDLE && match)
        pkt_pass_cnt <= pkt_pass_cnt + CNT_WIDTH'(1);
      if (accept && state == IDLE && !match)
        pkt_drop_cnt <= pkt_drop_cnt + CNT_WIDTH'(1);
      if (fwd_beat) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= s_axis_tlast;
        m_axis_tdata  <= s_axis_tdata;
        m_axis_tkeep  <= s_axis_tkeep;
        m_axis_tuser  <= s_axis_tuser;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rmt_pkt_filter.sv
// tb_rmt_pkt_filter: random packet traffic against a packet-level scoreboard model.
module tb_rmt_pkt_filter;
  typedef struct packed {
    logic         last;
    logic [63:0]  keep;
    logic [127:0] user;
    logic [511:0] data;
  } beat_t;
  logic clk = 1'b0, aresetn = 1'b0;
  logic [511:0] s_axis_tdata = '0, m_axis_tdata;
  logic [63:0] s_axis_tkeep = '0, m_axis_tkeep;
  logic [127:0] s_axis_tuser = '0, m_axis_tuser;
  logic s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
  logic m_axis_tvalid, m_axis_tlast, m_axis_tready = 1'b0;
  logic [31:0] pkt_pass_cnt, pkt_drop_cnt;
  int errs = 0, checks = 0;
  beat_t pkt[$], exp_q[$];
  bit pkt_drop, first_beat;
  int pass_n = 0, drop_n = 0;
  always #5 clk = ~clk;
  rmt_pkt_filter dut (
    .clk(clk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .pkt_pass_cnt(pkt_pass_cnt), .pkt_drop_cnt(pkt_drop_cnt)
  );
  task automatic check(string tag, logic [704:0] got, logic [704:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic beat_t rand_beat(bit last);
    beat_t b;
    for (int i = 0; i < 16; i++) b.data[i*32 +: 32] = $urandom;
    for (int i = 0; i < 4; i++) b.user[i*32 +: 32] = $urandom;
    b.keep = ($urandom_range(0, 7) == 0) ? 64'h0 : {$urandom, $urandom};
    b.last = last;
    return b;
  endfunction
  // kinds: 0 UDP, 1 TCP, 2 ARP first beat with match pattern later, 3 random header
  task automatic new_pkt(int kind);
    int len = $urandom_range(1, 4);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b = rand_beat(i == len - 1);
      if (kind != 3) begin
        b.data[143:128] = (kind == 2 && i == 0) ? 16'h0608 : 16'h0008;
        b.data[223:216] = (kind == 1) ? 8'h06 : 8'h11;
      end
      pkt.push_back(b);
    end
    pkt_drop = !(pkt[0].data[143:128] == 16'h0008 && pkt[0].data[223:216] == 8'h11);
    first_beat = 1'b1;
  endtask
  task automatic cycle(bit v, bit rdy);
    bit full;
    beat_t b;
    @(negedge clk);
    if (pkt.size() == 0) new_pkt($urandom_range(0, 3));
    s_axis_tvalid = v;
    {s_axis_tlast, s_axis_tkeep, s_axis_tuser, s_axis_tdata} = pkt[0];
    m_axis_tready = rdy;
    #1;
    check("pass_cnt", 705'(pkt_pass_cnt), 705'(pass_n));
    check("drop_cnt", 705'(pkt_drop_cnt), 705'(drop_n));
    full = exp_q.size() != 0;
    check("m_valid", 705'(m_axis_tvalid), 705'(full));
    if (m_axis_tvalid && full)
      check("m_beat", {m_axis_tlast, m_axis_tkeep, m_axis_tuser, m_axis_tdata}, exp_q[0]);
    if (m_axis_tvalid && rdy && full) void'(exp_q.pop_front());
    if (v) check("s_ready", 705'(s_axis_tready), 705'(pkt_drop || !full || rdy));
    if (v && s_axis_tready) begin
      b = pkt.pop_front();
      if (first_beat) begin
        if (pkt_drop) drop_n++;
        else pass_n++;
        first_beat = 1'b0;
      end
      if (!pkt_drop) exp_q.push_back(b);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2 aresetn = 1'b0;
    s_axis_tvalid = 1'b0;
    #1;
    check("rst_m_valid", 705'(m_axis_tvalid), 705'(0));
    check("rst_m_beat", {m_axis_tlast, m_axis_tkeep, m_axis_tuser, m_axis_tdata}, 705'(0));
    check("rst_pass_cnt", 705'(pkt_pass_cnt), 705'(0));
    check("rst_drop_cnt", 705'(pkt_drop_cnt), 705'(0));
    check("rst_s_ready", 705'(s_axis_tready), 705'(1));
    exp_q.delete();
    pkt.delete();
    pass_n = 0;
    drop_n = 0;
    @(negedge clk);
    #2 aresetn = 1'b1;
  endtask
  initial begin
    do_reset();
    for (int i = 0; i < 300; i++) cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    for (int i = 0; i < 200; i++) cycle(1'b1, 1'b1);
    for (int i = 0; i < 200; i++) cycle(1'b1, i % 4 == 0 || i % 4 == 3);
    while (pkt.size() < 2 || first_beat) cycle(1'b1, 1'b1);
    do_reset();
    for (int i = 0; i < 300; i++) cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
